// File: rtl/sequencer.sv
// Moore fetch/execute control sequencer for the basic processor.
// Emits one sysbus control word per clock from state, op and z_flag.
module sequencer #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            PC_bus,
  output logic            INC_PC,
  output logic            load_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            CS,
  output logic            R_NW,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_add,
  output logic            ALU_xor,
  output logic            ALU_inc,
  output logic            halted
);

  if (OP_W < 3 || OP_W > WORD_W) begin : g_bad_params
    sequencer_illegal_op_width u_bad ();
  end

  localparam logic [2:0] START   = 3'd0;
  localparam logic [2:0] FETCH_A = 3'd1;
  localparam logic [2:0] FETCH_B = 3'd2;
  localparam logic [2:0] EXEC_A  = 3'd3;
  localparam logic [2:0] EXEC_B  = 3'd4;
  localparam logic [2:0] EXEC_C  = 3'd5;
  localparam logic [2:0] HALT    = 3'd6;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_INC   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef struct packed {
    logic pc_bus;
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic addr_bus;
    logic load_mar;
    logic mdr_bus;
    logic load_mdr;
    logic cs;
    logic r_nw;
    logic acc_bus;
    logic load_acc;
    logic alu_add;
    logic alu_xor;
    logic alu_inc;
    logic halted;
  } ctrl_t;

  logic [2:0] state;
  logic [2:0] state_nx;
  ctrl_t      c;

  // State register; reset forces START at once, aborting any access.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= START;
    else          state <= state_nx;
  end

  // Next-state: op only matters in execute states, z_flag never does.
  always_comb begin
    state_nx = START;
    case (state)
      START:   state_nx = FETCH_A;
      FETCH_A: state_nx = FETCH_B;
      FETCH_B: state_nx = EXEC_A;
      EXEC_A: begin
        if (op == OP_INC)       state_nx = FETCH_A;
        else if (op == OP_HALT) state_nx = HALT;
        else                    state_nx = EXEC_B;
      end
      EXEC_B: begin
        if (op == OP_LDE) state_nx = EXEC_C;
        else              state_nx = FETCH_A;
      end
      EXEC_C:  state_nx = FETCH_A;
      HALT:    state_nx = HALT;
      default: state_nx = START;
    endcase
  end

  // Control word decode; every strobe defaults low.
  always_comb begin
    c = '0;
    case (state)
      FETCH_A: begin
        c.pc_bus   = 1'b1;
        c.load_mar = 1'b1;
        c.inc_pc   = 1'b1;
      end
      FETCH_B: begin
        c.cs      = 1'b1;
        c.r_nw    = 1'b1;
        c.mdr_bus = 1'b1;
        c.load_ir = 1'b1;
      end
      EXEC_A: begin
        if (op == OP_INC) begin
          c.alu_inc  = 1'b1;
          c.load_acc = 1'b1;
        end else if (op != OP_HALT) begin
          c.addr_bus = 1'b1;
          c.load_mar = 1'b1;
        end
      end
      EXEC_B: begin
        unique case (1'b1)
          op == OP_LOAD,
          op == OP_ADD,
          op == OP_XOR: begin
            c.cs       = 1'b1;
            c.r_nw     = 1'b1;
            c.mdr_bus  = 1'b1;
            c.load_acc = 1'b1;
            c.alu_add  = (op == OP_ADD);
            c.alu_xor  = (op == OP_XOR);
          end
          op == OP_STORE: begin
            c.cs       = 1'b1;
            c.acc_bus  = 1'b1;
            c.load_mdr = 1'b1;
          end
          op == OP_LDE: begin
            c.cs       = 1'b1;
            c.r_nw     = 1'b1;
            c.mdr_bus  = 1'b1;
            c.load_mar = 1'b1;
          end
          op == OP_BNE: begin
            c.cs      = !z_flag;
            c.r_nw    = !z_flag;
            c.mdr_bus = !z_flag;
            c.load_pc = !z_flag;
          end
          default: c = '0;
        endcase
      end
      EXEC_C: begin
        c.cs       = 1'b1;
        c.r_nw     = 1'b1;
        c.mdr_bus  = 1'b1;
        c.load_acc = 1'b1;
      end
      HALT:    c.halted = 1'b1;
      default: c = '0;
    endcase
  end

  assign PC_bus   = c.pc_bus;
  assign INC_PC   = c.inc_pc;
  assign load_PC  = c.load_pc;
  assign load_IR  = c.load_ir;
  assign Addr_bus = c.addr_bus;
  assign load_MAR = c.load_mar;
  assign MDR_bus  = c.mdr_bus;
  assign load_MDR = c.load_mdr;
  assign CS       = c.cs;
  assign R_NW     = c.r_nw;
  assign ACC_bus  = c.acc_bus;
  assign load_ACC = c.load_acc;
  assign ALU_add  = c.alu_add;
  assign ALU_xor  = c.alu_xor;
  assign ALU_inc  = c.alu_inc;
  assign halted   = c.halted;

endmodule

// File: doc/sequencer.md
# sequencer

Control sequencer for the basic processor. It is a Moore fetch/execute state machine that drives every strobe on the shared `sysbus`: the PC, IR, ACC and ALU controls, and the MAR/MDR/CS/R_NW lines consumed by the ROM and RAM blocks. It sits directly upstream of the memory blocks and the datapath. It takes the IR opcode field and the accumulator zero flag, and emits one control word per clock.

## Interface
- `WORD_W`, default 8: system bus word width.
- `OP_W`, default 3: opcode field width. The upper `OP_W` bits of the IR hold the opcode.

- `clock`, in, 1: system clock; all state changes on the rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `op`, in, `OP_W`: opcode from the IR. Valid from the cycle after `load_IR`.
- `z_flag`, in, 1: high when ACC == 0.
- `PC_bus`, out, 1: PC drives `sysbus`.
- `INC_PC`, out, 1: PC increments at the clock edge.
- `load_PC`, out, 1: PC loads from `sysbus`.
- `load_IR`, out, 1: IR loads from `sysbus`.
- `Addr_bus`, out, 1: IR operand field, zero-extended, drives `sysbus`.
- `load_MAR`, out, 1: memory address registers load from `sysbus`.
- `MDR_bus`, out, 1: the selected memory drives `sysbus`.
- `load_MDR`, out, 1: memory data register loads from `sysbus`.
- `CS`, out, 1: memory chip select.
- `R_NW`, out, 1: 1 = read, 0 = write.
- `ACC_bus`, out, 1: ACC drives `sysbus`.
- `load_ACC`, out, 1: ACC loads the ALU result.
- `ALU_add`, `ALU_xor`, `ALU_inc`, out, 1 each: ALU function select. All low means pass-through of `sysbus`.
- `halted`, out, 1: high while in HALT.

## Operation

**Opcode encodings**
- LOAD = 000, STORE = 001, ADD = 010, XOR = 011, INC = 100, LDE = 101, BNE = 110, HALT = 111.

**States:** START, FETCH_A, FETCH_B, EXEC_A, EXEC_B, EXEC_C, HALT. Outputs are a function of state, `op` and `z_flag` only. Any signal not listed for a state is 0.

- **START**: all outputs 0. Next state FETCH_A.
- **FETCH_A**: `PC_bus`, `load_MAR`, `INC_PC`. Next FETCH_B.
- **FETCH_B**: `CS`, `R_NW`, `MDR_bus`, `load_IR`. Next EXEC_A.
- **EXEC_A**
  - INC: `ALU_inc`, `load_ACC`. Next FETCH_A.
  - HALT: no outputs. Next HALT.
  - All other opcodes: `Addr_bus`, `load_MAR`. Next EXEC_B.
- **EXEC_B**
  - LOAD: `CS`, `R_NW`, `MDR_bus`, `load_ACC`. Next FETCH_A.
  - ADD or XOR: as LOAD, plus `ALU_add` or `ALU_xor` respectively. Next FETCH_A.
  - STORE: `CS`, `R_NW`=0, `ACC_bus`, `load_MDR`. Next FETCH_A.
  - LDE (indirect load): `CS`, `R_NW`, `MDR_bus`, `load_MAR`. Next EXEC_C.
  - BNE (indirect branch; the target is the word held at the operand address):
    - z_flag = 0: `CS`, `R_NW`, `MDR_bus`, `load_PC`.
    - z_flag = 1: no outputs.
    - Next FETCH_A in both cases.
- **EXEC_C** (LDE only): `CS`, `R_NW`, `MDR_bus`, `load_ACC`. Next FETCH_A.
- **HALT**: `halted`=1, all other outputs 0. Stays in HALT until reset.

**Rules**
- Bus exclusivity: at most one of `PC_bus`, `Addr_bus`, `MDR_bus`, `ACC_bus` is high in any cycle.
- At most one ALU select is high in any cycle.
- `load_ACC` is never high in the same cycle as `ACC_bus`.
- `op` is sampled only in EXEC_A, EXEC_B and EXEC_C. `op` changes during FETCH_A and FETCH_B are ignored.
- The next-state default is START, so illegal state codes recover through START.

## Timing
- Reset: while `n_reset` is low, the state is START immediately (asynchronous) and all outputs are 0, including `halted`.
  - First cycle after release: START.
  - Second cycle: FETCH_A.
- Reset asserted mid-instruction aborts it at once. No partial write is issued after reset assertion.
- Cycle counts per instruction, FETCH_A through the last execute state:
  - INC, HALT entry: 3.
  - LOAD, STORE, ADD, XOR, BNE taken, BNE not taken: 4.
  - LDE: 5.
- `z_flag` is sampled combinationally in EXEC_B only.
  - A `z_flag` change in EXEC_A has no effect.
  - The ACC result of an INC is visible to the following BNE, because there is at least one FETCH between them.
- `INC_PC` in FETCH_A and `load_PC` in BNE's EXEC_B are never in the same cycle, so a branch target always overrides the incremented PC.

## Test plan
- **Reset sequence:** `n_reset` low for 3 cycles, then high → outputs all 0 during reset and in START; FETCH_A in the second cycle after release with `PC_bus`=`load_MAR`=`INC_PC`=1.
- **LOAD then STORE:** `op`=000, then `op`=001 → LOAD gives the 4-cycle pattern ending in `load_ACC`=1 with `R_NW`=1. STORE's EXEC_B has `CS`=1, `R_NW`=0, `ACC_bus`=1, and `MDR_bus`=0.
- **LDE, INC, XOR:** `op`=101 → 5 cycles, with `load_MAR` high in both EXEC_A and EXEC_B. `op`=100 → 3 cycles with `ALU_inc`=`load_ACC`=1. `op`=011 → `ALU_xor` high only in EXEC_B.
- **BNE both ways:** `op`=110 with `z_flag`=0 in EXEC_B → `load_PC`=1 and `MDR_bus`=1. With `z_flag`=1 → all outputs 0 in EXEC_B and next state FETCH_A. Toggling `z_flag` in EXEC_A has no effect.
- **HALT and reset mid-instruction:** `op`=111 → `halted`=1 from the fourth cycle onward, held for 20 cycles with no strobes. Reset asserted in EXEC_B of a STORE → `CS` and `ACC_bus` drop in the same cycle, and the restart proceeds from START.
- **Checkers throughout:** bus-exclusivity and single-ALU-select assertions run on every test.
